// File: rtl/alu_sequencer.sv
// ALU sequencing stage: operand select, request strobe, settle wait,
// result capture and writeback handshake.
package pkg;
    typedef enum logic [3:0] {
        ADD, SUB, SLL, SRL, SRA, SLT, SLTU,
        XOR_OP, OR_OP, AND_OP,
        LT, LTU, GE, GEU, EQ, NE
    } alu_op;
endpackage

module alu_sequencer
    import pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  alu_op       op_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    input  logic [31:0] imm_i,
    input  logic [31:0] pc_i,
    input  logic        use_imm_i,
    input  logic        use_pc_i,
    input  logic [4:0]  rd_i,
    output logic        alu_req_o,
    output alu_op       alu_operator_o,
    output logic [31:0] alu_op_a_o,
    output logic [31:0] alu_op_b_o,
    input  logic [31:0] alu_result_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] result_o,
    output logic [4:0]  rd_o,
    output logic        we_o,
    output logic        branch_o,
    output logic        taken_o,
    output logic [31:0] target_o
);

    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("SETTLE_CYCLES must be >= 1");
    end

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE, SETUP, PULSE, WAIT, DONE
    } state_t;

    state_t       state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [4:0]   rd_q;
    logic         branch_q;
    logic [31:0]  target_q;
    logic         accept;
    logic         is_branch;
    logic         capture;

    assign in_ready_o = !rst_i &&
        ((state_q == IDLE) || (state_q == DONE && out_ready_i));
    assign accept  = in_valid_i && in_ready_o;
    assign capture = (state_q == WAIT) && (cnt_q == '0);
    assign is_branch = op_i inside {LT, LTU, GE, GEU, EQ, NE};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (accept) state_d = SETUP;
            SETUP: state_d = PULSE;
            PULSE: state_d = WAIT;
            WAIT:  if (cnt_q == '0) state_d = DONE;
            DONE:  if (out_ready_i) state_d = in_valid_i ? SETUP : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            alu_req_o      <= 1'b0;
            alu_operator_o <= ADD;
            alu_op_a_o     <= '0;
            alu_op_b_o     <= '0;
            rd_q           <= '0;
            branch_q       <= 1'b0;
            target_q       <= '0;
            out_valid_o    <= 1'b0;
            result_o       <= '0;
            rd_o           <= '0;
            we_o           <= 1'b0;
            branch_o       <= 1'b0;
            taken_o        <= 1'b0;
            target_o       <= '0;
        end else begin
            state_q <= state_d;
            // Strobe is a registered copy of PULSE, so the ALU sees a
            // clean edge with operands already a full cycle old.
            alu_req_o <= (state_q == PULSE);
            if (state_q == PULSE)
                cnt_q <= CW'(SETTLE_CYCLES - 1);
            else if (state_q == WAIT && cnt_q != '0)
                cnt_q <= cnt_q - 1'b1;
            if (accept) begin
                alu_operator_o <= op_i;
                alu_op_a_o <= (!is_branch && use_pc_i) ? pc_i : rs1_i;
                alu_op_b_o <= (!is_branch && use_imm_i) ? imm_i : rs2_i;
                rd_q       <= rd_i;
                branch_q   <= is_branch;
                target_q   <= pc_i + imm_i;
            end
            if (capture) begin
                out_valid_o <= 1'b1;
                result_o    <= alu_result_i;
                rd_o        <= rd_q;
                we_o        <= !branch_q && (rd_q != 5'd0);
                branch_o    <= branch_q;
                taken_o     <= branch_q && alu_result_i[0];
                target_o    <= branch_q ? target_q : 32'd0;
            end else if (state_q == DONE && out_ready_i) begin
                out_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: vector table plus hand sequences
// for backpressure, back-to-back, reset abort and SETTLE_CYCLES=1.
module tb_alu_sequencer;
    import pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    alu_op       op = ADD;
    logic [31:0] rs1 = '0, rs2 = '0, imm = '0, pc = '0;
    logic        use_imm = 1'b0, use_pc = 1'b0;
    logic [4:0]  rd = '0;

    logic        in_ready, alu_req, out_valid, we, br, tk;
    alu_op       alu_operator;
    logic [31:0] op_a, op_b, alu_res, result, target;
    logic [4:0]  rd_out;

    logic        in_valid2 = 1'b0;
    logic        out_ready2 = 1'b0;
    logic        in_ready2, alu_req2, out_valid2, we2, br2, tk2;
    alu_op       alu_operator2;
    logic [31:0] op_a2, op_b2, alu_res2, result2, target2;
    logic [4:0]  rd_out2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_sequencer #(.SETTLE_CYCLES(2)) dut (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .op_i(op), .rs1_i(rs1), .rs2_i(rs2), .imm_i(imm), .pc_i(pc),
        .use_imm_i(use_imm), .use_pc_i(use_pc), .rd_i(rd),
        .alu_req_o(alu_req), .alu_operator_o(alu_operator),
        .alu_op_a_o(op_a), .alu_op_b_o(op_b), .alu_result_i(alu_res),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .result_o(result), .rd_o(rd_out), .we_o(we),
        .branch_o(br), .taken_o(tk), .target_o(target)
    );

    alu_sequencer #(.SETTLE_CYCLES(1)) dut1 (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid2), .in_ready_o(in_ready2),
        .op_i(op), .rs1_i(rs1), .rs2_i(rs2), .imm_i(imm), .pc_i(pc),
        .use_imm_i(use_imm), .use_pc_i(use_pc), .rd_i(rd),
        .alu_req_o(alu_req2), .alu_operator_o(alu_operator2),
        .alu_op_a_o(op_a2), .alu_op_b_o(op_b2), .alu_result_i(alu_res2),
        .out_valid_o(out_valid2), .out_ready_i(out_ready2),
        .result_o(result2), .rd_o(rd_out2), .we_o(we2),
        .branch_o(br2), .taken_o(tk2), .target_o(target2)
    );

    function automatic logic [31:0] alu_f(alu_op o, logic [31:0] a,
                                          logic [31:0] b);
        case (o)
            ADD:    return a + b;
            SUB:    return a - b;
            SLL:    return a << b[4:0];
            SRL:    return a >> b[4:0];
            SRA:    return $signed(a) >>> b[4:0];
            XOR_OP: return a ^ b;
            OR_OP:  return a | b;
            AND_OP: return a & b;
            SLT, LT: return {31'd0, $signed(a) < $signed(b)};
            SLTU, LTU: return {31'd0, a < b};
            GE:     return {31'd0, $signed(a) >= $signed(b)};
            GEU:    return {31'd0, a >= b};
            EQ:     return {31'd0, a == b};
            NE:     return {31'd0, a != b};
            default: return 32'd0;
        endcase
    endfunction

    // ALU models: latch on request rising edge.
    initial alu_res = '0;
    initial alu_res2 = '0;
    always @(posedge alu_req) alu_res = alu_f(alu_operator, op_a, op_b);
    always @(posedge alu_req2) alu_res2 = alu_f(alu_operator2, op_a2, op_b2);

    typedef struct {
        alu_op       op;
        logic [31:0] rs1, rs2, imm, pc;
        logic        use_imm, use_pc;
        logic [4:0]  rd;
        logic [31:0] ea, eb, eres;
        logic        ewe, ebr, etk;
        logic [31:0] etgt;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        op = v.op; rs1 = v.rs1; rs2 = v.rs2; imm = v.imm; pc = v.pc;
        use_imm = v.use_imm; use_pc = v.use_pc; rd = v.rd;
    endtask

    task automatic check_out(vec_t v);
        chk("out_valid", out_valid, 1);
        chk("result", result, v.eres);
        chk("rd_o", rd_out, v.rd);
        chk("we", we, v.ewe);
        chk("branch", br, v.ebr);
        chk("taken", tk, v.etk);
        chk("target", target, v.etgt);
    endtask

    // Issue one instruction and wait for its result; leaves DUT in DONE.
    task automatic issue(vec_t v);
        bit got;
        int req_n, req_k, lat;
        @(negedge clk);
        drive(v);
        in_valid = 1'b1;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (in_ready) got = 1;
            else @(negedge clk);
        end
        chk("accept", 32'(got), 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("op_a", op_a, v.ea);
        chk("op_b", op_b, v.eb);
        chk("operator", 32'(alu_operator), 32'(v.op));
        req_n = 0; req_k = 0; lat = 0;
        for (int k = 1; k <= 12 && lat == 0; k++) begin
            @(posedge clk);
            #1;
            if (alu_req) begin req_n++; req_k = k; end
            if (out_valid) lat = k;
        end
        chk("latency", lat, 4);
        chk("req_edge", req_k, 2);
        chk("req_count", req_n, 1);
        check_out(v);
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("valid_clear", out_valid, 0);
        chk("ready_idle", in_ready, 1);
        out_ready = 1'b0;
    endtask

    initial begin
        int req_k[$];
        int val_k[$];
        int lat;
        vec_t v;

        vecs[0] = '{ADD, 32'd5, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0, 5'd3,
                    32'd5, 32'd7, 32'd12, 1'b1, 1'b0, 1'b0, 32'd0};
        vecs[1] = '{EQ, 32'h10, 32'h10, 32'hFFFFFFF8, 32'h100, 1'b1, 1'b0,
                    5'd5, 32'h10, 32'h10, 32'd1, 1'b0, 1'b1, 1'b1, 32'hF8};
        vecs[2] = '{EQ, 32'h10, 32'h11, 32'hFFFFFFF8, 32'h100, 1'b1, 1'b0,
                    5'd5, 32'h10, 32'h11, 32'd0, 1'b0, 1'b1, 1'b0, 32'hF8};
        vecs[3] = '{ADD, 32'h20, 32'h99, 32'h5, 32'h0, 1'b1, 1'b0, 5'd0,
                    32'h20, 32'h5, 32'h25, 1'b0, 1'b0, 1'b0, 32'd0};
        vecs[4] = '{LT, 32'hFFFFFFFF, 32'd1, 32'd8, 32'hFFFFFFFC, 1'b0, 1'b1,
                    5'd4, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 1'b1, 1'b1,
                    32'h4};
        vecs[5] = '{SUB, 32'h7, 32'h8, 32'h10, 32'h1000, 1'b1, 1'b1, 5'd7,
                    32'h1000, 32'h10, 32'hFF0, 1'b1, 1'b0, 1'b0, 32'd0};
        vecs[6] = '{SLTU, 32'd1, 32'd2, 32'd0, 32'd0, 1'b0, 1'b0, 5'd9,
                    32'd1, 32'd2, 32'd1, 1'b1, 1'b0, 1'b0, 32'd0};
        vecs[7] = '{GEU, 32'd1, 32'd2, 32'h10, 32'h40, 1'b0, 1'b0, 5'd2,
                    32'd1, 32'd2, 32'd0, 1'b0, 1'b1, 1'b0, 32'h50};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("ready_in_reset", in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_ready", in_ready, 1);
        chk("rst_req", alu_req, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_op_a", op_a, 0);
        chk("rst_op_b", op_b, 0);
        chk("rst_operator", 32'(alu_operator), 32'(ADD));
        chk("rst_target", target, 0);
        chk("rst_we", we, 0);

        // Table
        for (int i = 0; i < 8; i++) begin
            issue(vecs[i]);
            release_out();
        end

        // Backpressure
        issue(vecs[0]);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_valid", out_valid, 1);
            chk("bp_result", result, 32'd12);
            chk("bp_rd", rd_out, 3);
            chk("bp_ready", in_ready, 0);
            chk("bp_req", alu_req, 0);
        end
        release_out();

        // Back-to-back
        @(negedge clk);
        v = vecs[0];
        v.rs1 = 32'd1; v.rs2 = 32'd2; v.rd = 5'd1;
        drive(v);
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("b2b_accept1", op_a, 1);
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                rs1 = 32'd10; rs2 = 32'd20; rd = 5'd2;
            end
            if (alu_req) req_k.push_back(k);
            if (out_valid) begin
                val_k.push_back(k);
                chk("b2b_result", result,
                    (val_k.size() == 1) ? 32'd3 : 32'd30);
                chk("b2b_rd", rd_out, (val_k.size() == 1) ? 1 : 2);
            end
            if (k == 5) begin
                chk("b2b_accept2", op_a, 10);
                chk("b2b_valid_low", out_valid, 0);
                in_valid = 1'b0;
            end
        end
        out_ready = 1'b0;
        chk("b2b_req_n", req_k.size(), 2);
        chk("b2b_val_n", val_k.size(), 2);
        if (req_k.size() == 2) chk("b2b_req_gap", req_k[1] - req_k[0], 5);
        if (val_k.size() == 2) chk("b2b_val_k", val_k[1], 9);

        // Reset during WAIT
        @(negedge clk);
        v = vecs[0];
        v.rs1 = 32'd1; v.rs2 = 32'd1;
        drive(v);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_req", alu_req, 0);
        chk("abort_valid", out_valid, 0);
        chk("abort_op_a", op_a, 0);
        rst = 1'b0;
        #1;
        chk("abort_idle", in_ready, 1);
        lat = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (out_valid || alu_req) lat++;
        end
        chk("abort_no_output", lat, 0);
        v = vecs[5];
        v.use_pc = 1'b0; v.use_imm = 1'b0;
        v.rs1 = 32'd9; v.rs2 = 32'd4;
        v.ea = 32'd9; v.eb = 32'd4; v.eres = 32'd5;
        issue(v);
        release_out();

        // SETTLE_CYCLES=1 instance
        @(negedge clk);
        drive(vecs[0]);
        chk("s1_ready", in_ready2, 1);
        in_valid2 = 1'b1;
        @(posedge clk);
        #1 in_valid2 = 1'b0;
        lat = 0;
        for (int k = 1; k <= 10 && lat == 0; k++) begin
            @(posedge clk);
            #1;
            if (alu_req2) chk("s1_req_edge", k, 2);
            if (out_valid2) lat = k;
        end
        chk("s1_latency", lat, 3);
        chk("s1_result", result2, 12);
        chk("s1_we", we2, 1);
        @(negedge clk);
        out_ready2 = 1'b1;
        @(posedge clk);
        #1;
        chk("s1_clear", out_valid2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
